// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM state encoding and ACK/NACK bus levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line plus a one-flop edge detector.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to 1 so an idle (pulled-up) bus produces no edges after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= line_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with 7-bit address: byte writes to rx_data, byte reads from tx_data, no clock stretching.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | bus idle or after STOP, waiting for START
// ST_ADDR      | shifting in 7-bit address plus R/W bit
// ST_ADDR_ACK  | driving ACK for a matched address
// ST_WR_DATA   | shifting in a byte from the master
// ST_WR_ACK    | driving ACK for a received byte
// ST_RD_DATA   | shifting out a byte to the master
// ST_RD_ACK    | sampling the master's ACK/NACK after a read byte
// ST_WAIT_STOP | not addressed or master NACKed; ignore bus until START/STOP
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (scl_in),
        .level   (scl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (sda_in),
        .level   (sda),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] shift_in;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    assign shift_in = {shift_q[6:0], sda};

    // ack_q marks the second half of an ACK slot: in the ACK states it means SDA
    // is already pulled, in ST_RD_ACK it means the master ACKed and a reload is due.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ack_d   = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            ack_d   = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            cnt_d = '0;
                            if (addr_hit(shift_in, SLAVE_ADDR)) begin
                                state_d  = ST_ADDR_ACK;
                                rw_d     = sda;
                                busy_d   = 1'b1;
                                tx_req_d = sda;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_d = 1'b1;
                            oe_d  = ~I2C_ACK;
                        end else begin
                            ack_d = 1'b0;
                            oe_d  = 1'b0;
                            cnt_d = '0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d = ST_RD_DATA;
                                shift_d = tx_data;
                                oe_d    = ~tx_data[7];
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            cnt_d      = '0;
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            state_d    = ST_WR_ACK;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            cnt_d   = '0;
                            oe_d    = 1'b0;
                            ack_d   = 1'b0;
                            state_d = ST_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], shift_q[7]};
                            oe_d    = ~shift_q[6];
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && !ack_q) begin
                        if (sda == I2C_ACK) begin
                            tx_req_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_d   = 1'b0;
                        cnt_d   = '0;
                        shift_d = tx_data;
                        oe_d    = ~tx_data[7];
                        state_d = ST_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Scoreboard bench for i2c_slave: bus-master tasks post observations, a monitor compares them.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    typedef struct {
        string name;
        int    act;
        int    exp;
    } obs_t;

    obs_t       obs_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_plan[$];
    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int txreq_cnt = 0;
    int oe_cnt = 0;

    function automatic void post(input string n, input int a, input int e);
        obs_t o;
        o.name = n;
        o.act  = a;
        o.exp  = e;
        obs_q.push_back(o);
    endfunction

    // Monitor: checks rx bytes against the expected queue, serves tx_data, drains observations.
    initial begin
        forever begin
            obs_t       o;
            logic [7:0] e;
            @(negedge clk);
            if (reset) begin
                if (rx_valid) begin
                    rx_cnt++;
                    total++;
                    if (exp_rx.size() == 0) begin
                        bad++;
                        $display("FAIL rx_unexpected: got %02h expected none", rx_data);
                    end else begin
                        e = exp_rx.pop_front();
                        if (rx_data !== e) begin
                            bad++;
                            $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
                        end
                    end
                end
                if (tx_req) begin
                    txreq_cnt++;
                    if (tx_plan.size() > 0) tx_data = tx_plan.pop_front();
                end
                if (sda_oe) oe_cnt++;
            end
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                total++;
                if (o.act !== o.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h expected %0h", o.name, o.act, o.exp);
                end
            end
        end
    end

    task automatic bit_w(input logic b);
        #20 m_sda = b;
        #60 scl = 1'b1;
        #80 scl = 1'b0;
    endtask

    task automatic bit_r(output logic b);
        #20 m_sda = 1'b1;
        #60 scl = 1'b1;
        #40 b = sda_bus;
        #40 scl = 1'b0;
    endtask

    task automatic i2c_start();
        #20 m_sda = 1'b1;
        #60 scl = 1'b1;
        #80 m_sda = 1'b0;
        #80 scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #20 m_sda = 1'b0;
        #60 scl = 1'b1;
        #80 m_sda = 1'b1;
        #80;
    endtask

    task automatic byte_w(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(ack);
    endtask

    task automatic byte_r(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            d[i] = b;
        end
        bit_w(ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, tq0, oe0;

        #31;
        post("rst_sda_oe", int'(sda_oe), 0);
        post("rst_rx_data", int'(rx_data), 0);
        post("rst_rx_valid", int'(rx_valid), 0);
        post("rst_tx_req", int'(tx_req), 0);
        post("rst_busy", int'(busy), 0);
        reset = 1'b1;
        #100;

        // write 0xA5 to 0x42
        rx0 = rx_cnt;
        exp_rx.push_back(8'hA5);
        i2c_start();
        byte_w(8'h84, ack);
        post("wr_addr_ack", int'(ack), 0);
        post("wr_busy", int'(busy), 1);
        byte_w(8'hA5, ack);
        post("wr_data_ack", int'(ack), 0);
        i2c_stop();
        #100;
        post("wr_busy_end", int'(busy), 0);
        post("wr_rx_pulses", rx_cnt - rx0, 1);

        // write to non-matching 0x43
        rx0 = rx_cnt;
        oe0 = oe_cnt;
        i2c_start();
        byte_w(8'h86, ack);
        post("miss_addr_nack", int'(ack), 1);
        post("miss_busy", int'(busy), 0);
        byte_w(8'h55, ack);
        post("miss_data_nack", int'(ack), 1);
        i2c_stop();
        #100;
        post("miss_oe_cycles", oe_cnt - oe0, 0);
        post("miss_rx_pulses", rx_cnt - rx0, 0);

        // read 0x3C, 0xC3 with ACK then NACK
        tq0 = txreq_cnt;
        tx_plan.push_back(8'h3C);
        tx_plan.push_back(8'hC3);
        i2c_start();
        byte_w(8'h85, ack);
        post("rd_addr_ack", int'(ack), 0);
        byte_r(d, 1'b0);
        post("rd_byte0", int'(d), 8'h3C);
        byte_r(d, 1'b1);
        post("rd_byte1", int'(d), 8'hC3);
        post("rd_busy_nack", int'(busy), 0);
        byte_r(d, 1'b1);
        post("rd_wait_stop_quiet", int'(d), 8'hFF);
        i2c_stop();
        #100;
        post("rd_tx_req_pulses", txreq_cnt - tq0, 2);

        // write 0x11, repeated START, read 0x5A
        rx0 = rx_cnt;
        exp_rx.push_back(8'h11);
        tx_plan.push_back(8'h5A);
        i2c_start();
        byte_w(8'h84, ack);
        post("rs_wr_addr_ack", int'(ack), 0);
        byte_w(8'h11, ack);
        post("rs_wr_data_ack", int'(ack), 0);
        i2c_start();
        byte_w(8'h85, ack);
        post("rs_rd_addr_ack", int'(ack), 0);
        byte_r(d, 1'b1);
        post("rs_rd_byte", int'(d), 8'h5A);
        i2c_stop();
        #100;
        post("rs_rx_pulses", rx_cnt - rx0, 1);

        // reset while slave drives read bit 3
        tq0 = txreq_cnt;
        tx_plan.push_back(8'h00);
        i2c_start();
        byte_w(8'h85, ack);
        post("rst_rd_addr_ack", int'(ack), 0);
        for (int i = 0; i < 4; i++) bit_r(ack);
        #60;
        post("rst_oe_before", int'(sda_oe), 1);
        reset = 1'b0;
        #1;
        post("rst_oe_async", int'(sda_oe), 0);
        post("rst_busy_async", int'(busy), 0);
        post("rst_rx_data_clr", int'(rx_data), 0);
        #19 reset = 1'b1;
        oe0 = oe_cnt;
        #20 scl = 1'b1;
        #80 scl = 1'b0;
        for (int i = 0; i < 3; i++) bit_r(ack);
        bit_w(1'b0);
        byte_r(d, 1'b1);
        post("rst_quiet_byte", int'(d), 8'hFF);
        post("rst_quiet_oe", oe_cnt - oe0, 0);
        i2c_stop();
        #100;
        post("rst_tx_req_pulses", txreq_cnt - tq0, 1);
        exp_rx.push_back(8'h7E);
        i2c_start();
        byte_w(8'h84, ack);
        post("rst_recover_ack", int'(ack), 0);
        byte_w(8'h7E, ack);
        i2c_stop();

        // STOP in the middle of a data byte
        rx0 = rx_cnt;
        i2c_start();
        byte_w(8'h84, ack);
        post("part_addr_ack", int'(ack), 0);
        bit_w(1'b1);
        bit_w(1'b0);
        bit_w(1'b1);
        bit_w(1'b1);
        i2c_stop();
        #100;
        post("part_busy", int'(busy), 0);
        post("part_sda_oe", int'(sda_oe), 0);
        post("part_rx_pulses", rx_cnt - rx0, 0);

        post("rx_queue_left", exp_rx.size(), 0);
        post("tx_plan_left", tx_plan.size(), 0);
        #100;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
